// File: rtl/enc16x4_scan_if.sv
// Line-vector load and code-stream handshake bundle for enc16x4_scan.
// Latency: none, wires only.
// Backpressure: carries ready from the sink and en_n as a global pause.
interface enc16x4_scan_if;
  logic        en_n;   // active-low enable: 1 ignores load and pauses output
  logic        load;   // capture strobe for in
  logic [15:0] in;     // line vector, bit i <-> code i
  logic        ready;  // sink accepts code when valid & ready
  logic [3:0]  code;   // {A,B,C,D}, A = MSB
  logic        valid;
  logic        busy;
  logic        done;
  logic        zero;

  // Producer of line vectors / consumer of codes.
  modport master (
    output en_n, load, in, ready,
    input  code, valid, busy, done, zero
  );

  // The encoder itself.
  modport slave (
    input  en_n, load, in, ready,
    output code, valid, busy, done, zero
  );
endinterface

// File: rtl/enc16x4_scan.sv
// Sequential 16-to-4 encoder: captures a line vector, emits each set line index lowest first.
// Latency: first code valid one cycle after the accepted load; one code per cycle thereafter.
// Backpressure: ready low holds code/valid; en_n high drops valid and freezes all state.
module enc16x4_scan (
  input  logic             clk,
  input  logic             rst,
  enc16x4_scan_if.slave    bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t      state_q, state_d;
  logic [15:0] pend_q, pend_d;
  logic [3:0]  code_q, code_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        zero_q, zero_d;
  logic        accept;

  // Lowest set bit wins; an empty vector encodes to 0, which is also the
  // reset value of code, so code is stable at 0 whenever nothing is pending.
  function automatic logic [3:0] lsb_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Next-state logic: capture in IDLE, clear one pending bit per accepted code in SCAN.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    zero_d  = 1'b0;
    accept  = (state_q == SCAN) & ~bus.en_n & bus.ready;

    case (state_q)
      IDLE: begin
        if (bus.load && !bus.en_n) begin
          if (bus.in != 16'h0000) begin
            pend_d  = bus.in;
            state_d = SCAN;
          end else begin
            zero_d = 1'b1;
          end
        end
      end
      SCAN: begin
        // load is deliberately ignored here: no merge, no restart.
        if (accept) begin
          pend_d = pend_q & ~(16'h0001 << code_q);
          if (pend_d == 16'h0000) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = 16'h0000;
      end
    endcase

    // Registering the encode of the next pending vector keeps code a pure
    // flop output with no path from in/load/ready.
    code_d = lsb_index(pend_d);
    busy_d = (state_d == SCAN);
  end

  // State and registered outputs; synchronous reset discards any pending vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= 16'h0000;
      code_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
    end
  end

  // valid is gated by en_n combinationally so a pause takes effect in the same cycle.
  assign bus.code  = code_q;
  assign bus.valid = (state_q == SCAN) & ~bus.en_n;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.zero  = zero_q;

endmodule
